dcp_scan: RTL

Receive-side front end of the debug control processor (DCP). It consumes raw bytes from the UART receiver through a valid/ready handshake. On request from the DCP, it returns either one command character or one parsed hexadecimal word, together with line-end, error and digit-count status. It sits between the UART RX byte stream and the DCP command FSM and its child command modules.

---
 rtl/dcp_pkg.sv | 40 ++++
 rtl/dcp_scan_if.sv | 30 +++
 rtl/dcp_hex_nibble.sv | 28 ++
 rtl/dcp_scan.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dcp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcp_pkg
// Brief    : Shared types and ASCII constants for the DCP receive front end.
// Revision : 1.0 - initial release
// ============================================================================
package dcp_pkg;

    // Scanner FSM state encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SKIP  = 3'd1,
        ST_ACCUM = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] SP  = 8'h20;
    localparam logic [7:0] TAB = 8'h09;
    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] BS  = 8'h08;
    localparam logic [7:0] DEL = 8'h7F;

    localparam logic TYPE_CHAR = 1'b0;
    localparam logic TYPE_HEX  = 1'b1;

    // Digit count value reported once more than eight digits were seen
    localparam logic [3:0] NDIG_OVF = 4'd9;

    function automatic logic is_blank(input logic [7:0] b);
        return (b == SP) || (b == TAB);
    endfunction

    function automatic logic is_eol(input logic [7:0] b);
        return (b == CR) || (b == LF);
    endfunction

endpackage : dcp_pkg
`default_nettype wire

// File: rtl/dcp_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : dcp_scan_if
// Brief    : UART RX byte stream plus DCP request/response bundle.
//            master = UART RX / DCP side, slave = dcp_scan.
// Revision : 1.0 - initial release
// ============================================================================
interface dcp_scan_if;
    logic [7:0]  d_rx;
    logic        vld_rx;
    logic        rdy_rx;
    logic        req_rx;
    logic        type_rx;
    logic        ack_rx;
    logic [31:0] din_rx;
    logic        flag_rx;
    logic        err_rx;
    logic [3:0]  ndig_rx;

    modport master (
        output d_rx, vld_rx, req_rx, type_rx,
        input  rdy_rx, ack_rx, din_rx, flag_rx, err_rx, ndig_rx
    );

    modport slave (
        input  d_rx, vld_rx, req_rx, type_rx,
        output rdy_rx, ack_rx, din_rx, flag_rx, err_rx, ndig_rx
    );
endinterface : dcp_scan_if
`default_nettype wire

// File: rtl/dcp_hex_nibble.sv
`default_nettype none
// ============================================================================
// Module   : dcp_hex_nibble
// Brief    : ASCII hex digit (0-9, a-f, A-F) to 4-bit value decoder.
// Revision : 1.0 - initial release
// ============================================================================
module dcp_hex_nibble (
    input  wire logic [7:0] ascii,
    output logic      [3:0] nibble,
    output logic            valid
);

    // Letters share the low nibble pattern 1..6, so add 9 to reach 10..15
    always_comb begin
        nibble = 4'd0;
        valid  = 1'b0;
        if (ascii >= 8'h30 && ascii <= 8'h39) begin
            nibble = ascii[3:0];
            valid  = 1'b1;
        end else if ((ascii >= 8'h41 && ascii <= 8'h46) ||
                     (ascii >= 8'h61 && ascii <= 8'h66)) begin
            nibble = ascii[3:0] + 4'd9;
            valid  = 1'b1;
        end
    end

endmodule : dcp_hex_nibble
`default_nettype wire

// File: rtl/dcp_scan.sv
`default_nettype none
// ============================================================================
// Module   : dcp_scan
// Brief    : DCP receive front end. Returns one command character or one
//            parsed hex word per request, with line-end/error/digit status.
// Config   : DCP_SCAN_BACKSPACE_EN - BS/DEL erase the last hex digit.
// Revision : 1.0 - initial release
// ============================================================================
module dcp_scan
    import dcp_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst_n,
    dcp_scan_if.slave   bus
);

    state_t      state;
    state_t      next_state;
    logic        mode;
    logic [31:0] acc;
    logic [3:0]  cnt;
    logic        rdy;
    logic        ack;
    logic        rdy_next;
    logic        ack_next;
    logic [31:0] din;
    logic        flag;
    logic        err;
    logic [3:0]  ndig;

    logic [7:0]  rx_byte;
    logic [3:0]  nib;
    logic        nib_vld;
    logic        xfer;
    logic        blank;
    logic        eol;
    logic        bs_hit;

    assign rx_byte = bus.d_rx;
    assign xfer    = bus.vld_rx && rdy;
    assign blank   = is_blank(rx_byte);
    assign eol     = is_eol(rx_byte);

`ifdef DCP_SCAN_BACKSPACE_EN
    assign bs_hit = (rx_byte == BS) || (rx_byte == DEL);
`else
    assign bs_hit = 1'b0;
`endif

    dcp_hex_nibble u_nibble (
        .ascii  (rx_byte),
        .nibble (nib),
        .valid  (nib_vld)
    );

    // State register; rdy/ack are registered copies of the next-state decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            rdy   <= 1'b0;
            ack   <= 1'b0;
        end else begin
            state <= next_state;
            rdy   <= rdy_next;
            ack   <= ack_next;
        end
    end

    // Next-state logic; a dropped request aborts any scanning state
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (bus.req_rx) next_state = ST_SKIP;
            end
            ST_SKIP: begin
                if (!bus.req_rx) begin
                    next_state = ST_IDLE;
                end else if (xfer && !blank && !bs_hit) begin
                    if (mode == TYPE_CHAR) begin
                        if (!eol) next_state = ST_DONE;
                    end else if (nib_vld) begin
                        next_state = ST_ACCUM;
                    end else if (eol) begin
                        next_state = ST_DONE;
                    end else begin
                        next_state = ST_DRAIN;
                    end
                end
            end
            ST_ACCUM: begin
                if (!bus.req_rx) begin
                    next_state = ST_IDLE;
                end else if (xfer && !nib_vld && !bs_hit) begin
                    if (blank || eol) next_state = ST_DONE;
                    else              next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!bus.req_rx)     next_state = ST_IDLE;
                else if (xfer && eol) next_state = ST_DONE;
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Output decode of the upcoming state (registered in the state process)
    always_comb begin
        rdy_next = 1'b0;
        ack_next = 1'b0;
        case (next_state)
            ST_SKIP, ST_ACCUM, ST_DRAIN: rdy_next = 1'b1;
            ST_DONE:                     ack_next = 1'b1;
            default: ;
        endcase
    end

    // Accumulator, digit count and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= TYPE_CHAR;
            acc  <= 32'd0;
            cnt  <= 4'd0;
            din  <= 32'd0;
            flag <= 1'b0;
            err  <= 1'b0;
            ndig <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_rx) begin
                        mode <= bus.type_rx;
                        acc  <= 32'd0;
                        cnt  <= 4'd0;
                    end
                end
                ST_SKIP: begin
                    if (bus.req_rx && xfer && !blank && !bs_hit) begin
                        if (mode == TYPE_CHAR) begin
                            if (!eol) begin
                                din  <= {24'd0, rx_byte};
                                flag <= 1'b0;
                                err  <= 1'b0;
                                ndig <= 4'd0;
                            end
                        end else if (nib_vld) begin
                            acc <= {acc[27:0], nib};
                            cnt <= 4'd1;
                        end else if (eol) begin
                            din  <= 32'd0;
                            flag <= 1'b1;
                            err  <= 1'b0;
                            ndig <= 4'd0;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (bus.req_rx && xfer) begin
                        if (nib_vld) begin
                            acc <= {acc[27:0], nib};
                            cnt <= (cnt == NDIG_OVF) ? NDIG_OVF : cnt + 4'd1;
                        end else if (bs_hit) begin
                            // Erase the newest digit; an overflowed high digit stays lost
                            if (cnt != 4'd0) begin
                                acc <= {4'd0, acc[31:4]};
                                cnt <= cnt - 4'd1;
                            end
                        end else if (blank || eol) begin
                            din  <= acc;
                            flag <= eol;
                            err  <= 1'b0;
                            ndig <= cnt;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus.req_rx && xfer && eol) begin
                        din  <= 32'd0;
                        flag <= 1'b1;
                        err  <= 1'b1;
                        ndig <= 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rdy_rx  = rdy;
    assign bus.ack_rx  = ack;
    assign bus.din_rx  = din;
    assign bus.flag_rx = flag;
    assign bus.err_rx  = err;
    assign bus.ndig_rx = ndig;

endmodule : dcp_scan
`default_nettype wire
